// File: rtl/truth_table_capture.sv
// Exhaustive truth-table scanner: steps x_out through every input combination,
// samples y_in at the end of each hold window and compares the result against a latched reference.
module truth_table_capture #(
   parameter int unsigned N_IN        = 3,
   parameter int unsigned HOLD_CYCLES = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2**N_IN-1:0]    expected,
   input  logic                  y_in,
   output logic [N_IN-1:0]       x_out,
   output logic                  busy,
   output logic                  done,
   output logic [2**N_IN-1:0]    table_out,
   output logic                  match
);
   localparam int unsigned TW = 2**N_IN;
   localparam int unsigned CW = $clog2(HOLD_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   x_q, x_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     table_q, table_d;
   logic [TW-1:0]     exp_q, exp_d;
   logic              match_q, match_d;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      exp_d   = exp_q;
      match_d = match_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SCAN;
               x_d     = '0;
               cnt_d   = '0;
               table_d = '0;
               exp_d   = expected;
               match_d = 1'b0;
            end
         end
         S_SCAN: begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               table_d[x_q] = y_in;
               if (x_q != '1) begin
                  x_d   = x_q + N_IN'(1);
                  cnt_d = '0;
               end else begin
                  // Compare uses the table including the sample just taken.
                  state_d = S_DONE;
                  x_d     = '0;
                  match_d = (table_d == exp_q);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         exp_q   <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         exp_q   <= exp_d;
         match_q <= match_d;
      end
   end

   assign x_out     = x_q;
   assign busy      = (state_q == S_SCAN);
   assign done      = (state_q == S_DONE);
   assign table_out = table_q;
   assign match     = match_q;
endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: two instances (hold 20 and hold 2) checked every cycle
// against an elapsed-time model, plus directed literal checks.
module tb_truth_table_capture;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_a, start_b;
   logic [7:0] exp_a, exp_b;
   logic [1:0] mode_a, mode_b;
   logic       y_a, y_b;
   logic [2:0] x_a, x_b;
   logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
   logic [7:0] tab_a, tab_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   // mode 0: x2^x1^x0, 1: x2&x1&x0, 2: x0, 3: constant 0
   function automatic logic yfunc(input logic [1:0] m, input logic [2:0] x);
      case (m)
         2'd0:    return ^x;
         2'd1:    return &x;
         2'd2:    return x[0];
         default: return 1'b0;
      endcase
   endfunction

   assign y_a = yfunc(mode_a, x_a);
   assign y_b = yfunc(mode_b, x_b);

   truth_table_capture #(.N_IN(3), .HOLD_CYCLES(20)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .y_in(y_a),
      .x_out(x_a), .busy(busy_a), .done(done_a), .table_out(tab_a), .match(match_a));

   truth_table_capture #(.N_IN(3), .HOLD_CYCLES(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .y_in(y_b),
      .x_out(x_b), .busy(busy_b), .done(done_b), .table_out(tab_b), .match(match_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
      end
   endtask

   // Model: elapsed edges since start acceptance determine vector and samples.
   int         hold[2] = '{20, 2};
   logic       m_scan[2], m_done[2], m_match[2];
   logic [7:0] m_tab[2], m_exp[2];
   int         m_el[2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
         logic       st;
         logic [7:0] ex, t;
         logic [1:0] md;
         int         el, i;
         st = (d == 0) ? start_a : start_b;
         ex = (d == 0) ? exp_a : exp_b;
         md = (d == 0) ? mode_a : mode_b;
         if (!rst_n) begin
            m_scan[d] <= 1'b0; m_done[d] <= 1'b0; m_match[d] <= 1'b0;
            m_tab[d] <= '0; m_exp[d] <= '0; m_el[d] <= 0;
         end else if (st && !m_scan[d]) begin
            m_scan[d] <= 1'b1; m_done[d] <= 1'b0; m_match[d] <= 1'b0;
            m_tab[d] <= '0; m_exp[d] <= ex; m_el[d] <= 0;
         end else if (m_scan[d]) begin
            el = m_el[d] + 1;
            t  = m_tab[d];
            if (el % hold[d] == 0) begin
               i = el / hold[d] - 1;
               t[i] = yfunc(md, 3'(i));
               if (i == 7) begin
                  m_scan[d]  <= 1'b0;
                  m_done[d]  <= 1'b1;
                  m_match[d] <= (t == m_exp[d]);
               end
            end
            m_el[d]  <= el;
            m_tab[d] <= t;
         end
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int d = 0; d < 2; d++) begin
            logic [2:0] ex_x;
            ex_x = m_scan[d] ? 3'(m_el[d] / hold[d]) : 3'd0;
            chk($sformatf("model_x[%0d]", d), (d == 0) ? x_a : x_b, ex_x);
            chk($sformatf("model_busy[%0d]", d), (d == 0) ? busy_a : busy_b, m_scan[d]);
            chk($sformatf("model_done[%0d]", d), (d == 0) ? done_a : done_b, m_done[d]);
            chk($sformatf("model_table[%0d]", d), (d == 0) ? tab_a : tab_b, m_tab[d]);
            if (m_done[d])
               chk($sformatf("model_match[%0d]", d), (d == 0) ? match_a : match_b, m_match[d]);
         end
      end
   end

   task automatic pulse(input int d, input logic [7:0] e, output int k);
      @(negedge clk);
      if (d == 0) begin start_a = 1'b1; exp_a = e; end
      else        begin start_b = 1'b1; exp_b = e; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      k = cyc;
   endtask

   task automatic wait_done(input int d, input int k, input int lat);
      while (!((d == 0) ? done_a : done_b) && (cyc - k) < lat + 40) @(negedge clk);
      chk("done_timeout", (d == 0) ? done_a : done_b, 1'b1);
      chk("done_latency", cyc - k, lat);
   endtask

   initial begin
      int k, dummy;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      exp_a = '0; exp_b = '0; mode_a = 2'd0; mode_b = 2'd2;
      repeat (3) @(negedge clk);
      chk("rst_x", x_a, 3'd0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_table", tab_a, 8'h00);
      chk("rst_match", match_a, 1'b0);
      rst_n = 1'b1;

      // 1: parity
      pulse(0, 8'h96, k);
      chk("t1_busy", busy_a, 1'b1);
      repeat (20) @(negedge clk);
      chk("t1_x_step", x_a, 3'd1);
      wait_done(0, k, 160);
      chk("t1_table", tab_a, 8'h96);
      chk("t1_match", match_a, 1'b1);

      // 2: AND, then wrong reference
      mode_a = 2'd1;
      pulse(0, 8'h80, k);
      wait_done(0, k, 160);
      chk("t2_table", tab_a, 8'h80);
      chk("t2_match", match_a, 1'b1);
      pulse(0, 8'h81, k);
      chk("t2_done_drop", done_a, 1'b0);
      wait_done(0, k, 160);
      chk("t2b_table", tab_a, 8'h80);
      chk("t2b_match", match_a, 1'b0);

      // 3: start during scan is ignored
      mode_a = 2'd0;
      pulse(0, 8'h96, k);
      repeat (49) @(negedge clk);
      pulse(0, 8'h00, dummy);
      wait_done(0, k, 160);
      chk("t3_table", tab_a, 8'h96);
      chk("t3_match", match_a, 1'b1);

      // 4: reset mid-scan
      pulse(0, 8'h96, k);
      while (x_a != 3'd3 && (cyc - k) < 100) @(negedge clk);
      chk("t4_reach_x3", x_a, 3'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t4_x", x_a, 3'd0);
      chk("t4_busy", busy_a, 1'b0);
      chk("t4_done", done_a, 1'b0);
      chk("t4_table", tab_a, 8'h00);
      pulse(0, 8'h96, k);
      wait_done(0, k, 160);
      chk("t4_table_after", tab_a, 8'h96);
      chk("t4_match_after", match_a, 1'b1);

      // 5: short hold instance, y = x0
      pulse(1, 8'hAA, k);
      wait_done(1, k, 16);
      chk("t5_table", tab_b, 8'hAA);
      chk("t5_match", match_b, 1'b1);

      // 6: restart from DONE with y stuck at 0
      mode_a = 2'd3;
      pulse(0, 8'h96, k);
      chk("t6_done_drop", done_a, 1'b0);
      chk("t6_busy", busy_a, 1'b1);
      chk("t6_table_clear", tab_a, 8'h00);
      wait_done(0, k, 160);
      chk("t6_table", tab_a, 8'h00);
      chk("t6_match", match_a, 1'b0);
      repeat (5) @(negedge clk);
      chk("t6_hold_done", done_a, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
